// File: rtl/ban_dffns_checker_if.sv
// Observation bundle between the ban_DFFNS cell environment and its falling-edge checker.
`timescale 1ns/1ps

interface ban_dffns_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             EN;
  logic             SN;
  logic             D;
  logic             Q;
  logic             QN;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_pulse;
  logic             fail;
  logic [1:0]       state;

  modport master (
    output EN, SN, D, Q, QN,
    input  match_cnt, err_cnt, err_pulse, fail, state
  );

  modport slave (
    input  EN, SN, D, Q, QN,
    output match_cnt, err_cnt, err_pulse, fail, state
  );
endinterface

// File: rtl/ban_dffns_checker.sv
// Falling-edge checker for the ban_DFFNS cell: one-stage reference model plus pass/fail counters.
// Define BAN_CHK_STICKY_FAIL_EN to make the FAIL state terminal until RN or EN=0.
`timescale 1ns/1ps

module ban_dffns_checker #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WARMUP = 2
) (
  input logic                  CKN,
  input logic                  RN,
  ban_dffns_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCheck = 2'd2,
    StFail  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [3:0]       WarmLast = 4'(WARMUP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pulse_q, pulse_d;
  logic             fail_q, fail_d;
  logic             exp_q, exp_d;
  logic [3:0]       warm_q, warm_d;
  logic             cmp_pass;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    fail_d   = fail_q;
    warm_d   = warm_q;
    // An asserted set forces the cell to 1 regardless of D.
    exp_d    = bus.SN ? bus.D : 1'b1;
    // X/Z on Q or QN leaves cmp_pass unknown, which takes the failing branch.
    cmp_pass = (bus.Q == exp_q) && (bus.QN == !exp_q);

    if (!bus.EN) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.SN) begin
            state_d = StArm;
            warm_d  = '0;
          end
        end
        StArm: begin
          if (!bus.SN) begin
            warm_d = '0;
          end else if (warm_q == WarmLast) begin
            state_d = StCheck;
          end else begin
            warm_d = warm_q + 4'd1;
          end
        end
        StCheck: begin
          if (bus.SN) begin
            if (cmp_pass) begin
              if (match_q != CntMax) match_d = match_q + 1'b1;
            end else begin
              if (err_q != CntMax) err_d = err_q + 1'b1;
              pulse_d = 1'b1;
              state_d = StFail;
`ifdef BAN_CHK_STICKY_FAIL_EN
              fail_d  = 1'b1;
`endif
            end
          end
        end
        StFail: begin
`ifdef BAN_CHK_STICKY_FAIL_EN
          state_d = StFail;
`else
          state_d = StCheck;
`endif
        end
        default: state_d = StIdle;
      endcase
    end

`ifndef BAN_CHK_STICKY_FAIL_EN
    fail_d = pulse_d;
`endif
  end

  always_ff @(negedge CKN) begin
    if (!RN) begin
      state_q <= StIdle;
      match_q <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
      fail_q  <= 1'b0;
      exp_q   <= 1'b1;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      fail_q  <= fail_d;
      exp_q   <= exp_d;
      warm_q  <= warm_d;
    end
  end

  assign bus.match_cnt = match_q;
  assign bus.err_cnt   = err_q;
  assign bus.err_pulse = pulse_q;
  assign bus.fail      = fail_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ban_dffns_checker.sv
// Scoreboard bench: directed edge vectors push expected outputs; a monitor pops one per CKN fall.
`timescale 1ns/1ps

module tb_ban_dffns_checker;

`ifdef BAN_CHK_STICKY_FAIL_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  typedef struct {
    logic [1:0] st;
    logic [7:0] m;
    logic [7:0] e;
    logic       p;
    logic       f;
    logic [3:0] m4;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;

  logic ckn = 1'b1;
  logic rn  = 1'b0;
  logic en  = 1'b0;
  logic sn  = 1'b1;
  logic d   = 1'b0;
  logic inj = 1'b0;
  logic cq  = 1'b1;
  logic q_w, qn_w;

  always #5 ckn = ~ckn;

  // Behavioural ban_DFFNS cell with a small clock-to-Q delay.
  always @(negedge ckn) cq <= #1 (sn ? d : 1'b1);
  always @(negedge sn)  cq <= #1 1'b1;
  assign q_w  = inj ? 1'b0 : cq;
  assign qn_w = ~cq;

  ban_dffns_checker_if #(.CNT_W(8)) bus8 ();
  ban_dffns_checker_if #(.CNT_W(4)) bus4 ();

  assign bus8.EN = en;
  assign bus8.SN = sn;
  assign bus8.D  = d;
  assign bus8.Q  = q_w;
  assign bus8.QN = qn_w;
  assign bus4.EN = en;
  assign bus4.SN = sn;
  assign bus4.D  = d;
  assign bus4.Q  = q_w;
  assign bus4.QN = qn_w;

  ban_dffns_checker #(.CNT_W(8), .WARMUP(2)) dut (
    .CKN (ckn),
    .RN  (rn),
    .bus (bus8)
  );

  ban_dffns_checker #(.CNT_W(4), .WARMUP(2)) dut4 (
    .CKN (ckn),
    .RN  (rn),
    .bus (bus4)
  );

  task automatic chk(input string name, input int e_no, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e_no, act, req);
    end
  endtask

  // Drive one edge's inputs and record what the checker should show after that edge.
  task automatic apply(input logic rn_v, input logic en_v, input logic sn_v, input logic d_v,
                       input logic inj_v, input logic [1:0] st, input int m, input int e,
                       input logic p, input logic f, input int m4);
    exp_t x;
    rn  = rn_v;
    en  = en_v;
    sn  = sn_v;
    d   = d_v;
    inj = inj_v;
    x.st = st;
    x.m  = 8'(m);
    x.e  = 8'(e);
    x.p  = p;
    x.f  = f;
    x.m4 = 4'(m4);
    sb_q.push_back(x);
    @(negedge ckn);
    @(posedge ckn);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge ckn);
      #2;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        chk("state", edge_no, 32'(bus8.state), 32'(x.st));
        chk("match_cnt", edge_no, 32'(bus8.match_cnt), 32'(x.m));
        chk("err_cnt", edge_no, 32'(bus8.err_cnt), 32'(x.e));
        chk("err_pulse", edge_no, 32'(bus8.err_pulse), 32'(x.p));
        chk("fail", edge_no, 32'(bus8.fail), 32'(x.f));
        chk("match_cnt_w4", edge_no, 32'(bus4.match_cnt), 32'(x.m4));
      end
      edge_no++;
    end
  end

  initial begin : stimulus
    // Reset for two edges, then arm: ARM for two edges, CHECK after the third.
    apply(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 1, 0, 2'd1, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 0, 2'd2, 0, 0, 0, 0, 0);
    // Clean stream of 20 compares; the 4-bit instance saturates at 15.
    for (int k = 1; k <= 20; k++) begin
      apply(1, 1, 1, logic'((k + 1) % 2), 0, 2'd2, k, 0, 0, 0, (k > 15) ? 15 : k);
    end
    // Q forced low while exp=1.
    apply(1, 1, 1, 0, 1, 2'd3, 20, 1, 1, 1, 15);
    apply(1, 1, 1, 1, 0, Sticky ? 2'd3 : 2'd2, 20, 1, 0, Sticky, 15);
    // EN low leaves FAIL/CHECK for IDLE with counters held.
    apply(1, 0, 1, 1, 0, 2'd0, 20, 1, 0, Sticky, 15);
    apply(1, 1, 1, 0, 0, 2'd1, 20, 1, 0, Sticky, 15);
    apply(1, 1, 1, 1, 0, 2'd1, 20, 1, 0, Sticky, 15);
    apply(1, 1, 1, 0, 0, 2'd2, 20, 1, 0, Sticky, 15);
    apply(1, 1, 1, 1, 0, 2'd2, 21, 1, 0, Sticky, 15);
    // Set held for three edges: compares skipped, then exp=1 is checked.
    apply(1, 1, 0, 0, 0, 2'd2, 21, 1, 0, Sticky, 15);
    apply(1, 1, 0, 1, 0, 2'd2, 21, 1, 0, Sticky, 15);
    apply(1, 1, 0, 0, 0, 2'd2, 21, 1, 0, Sticky, 15);
    apply(1, 1, 1, 0, 0, 2'd2, 22, 1, 0, Sticky, 15);
    apply(1, 1, 1, 1, 0, 2'd2, 23, 1, 0, Sticky, 15);
    apply(1, 0, 1, 0, 0, 2'd0, 23, 1, 0, Sticky, 15);
    // RN wins over EN=1 on the same edge.
    apply(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    @(negedge ckn);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 5000 ns");
    $fatal(1);
  end

endmodule
